// File: rtl/ptp_bridge_pkg.sv
// Shared PTP bridge types: per-beat segment info carried in tuser.
package ptp_bridge_pkg;

    localparam int BYTESVLD_W = 7;

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [BYTESVLD_W-1:0] bytesvld;
        logic [3:0]            port_id;
        logic [2:0]            pri;
    } SEGMENT_INFO_S;

    localparam int SEGMENT_INFO_WIDTH = $bits(SEGMENT_INFO_S);

endpackage

// File: rtl/ipbb_popcount.sv
// Population count of a byte-enable vector.
module ipbb_popcount #(
    parameter int IN_W  = 64,
    parameter int CNT_W = 7
) (
    input  logic [IN_W-1:0]  bits,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < IN_W; i++) begin
            cnt = cnt + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/igr_wadj_seg_merge.sv
// Ingress width adapter: packs narrow segmented beats into SOP-aligned wide words.
// Optional protocol checker enabled by IGR_WADJ_SEG_MERGE_ERR_CHK_EN.
module igr_wadj_seg_merge
    import ptp_bridge_pkg::*;
#(
    parameter int IN_TDATA_WIDTH     = 128,
    parameter int IN_NUM_SEG         = 2,
    parameter int OUT_TDATA_WIDTH    = 512,
    parameter int USERMETADATA_WIDTH = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_tvalid,
    output logic                                                 in_tready,
    input  logic [IN_NUM_SEG-1:0][IN_TDATA_WIDTH/IN_NUM_SEG-1:0] in_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]                          in_tkeep,
    input  logic                                                 in_tlast,
    input  logic [USERMETADATA_WIDTH-1:0]                        in_tuser_usermetadata,
    input  SEGMENT_INFO_S                                        in_tuser_segment_info,
    output logic                                                 out_tvalid,
    input  logic                                                 out_tready,
    output logic [OUT_TDATA_WIDTH-1:0]                           out_tdata,
    output logic [OUT_TDATA_WIDTH/8-1:0]                         out_tkeep,
    output logic                                                 out_tlast,
    output logic [USERMETADATA_WIDTH-1:0]                        out_tuser_usermetadata,
    output SEGMENT_INFO_S                                        out_tuser_segment_info,
    output logic                                                 err_sticky
);

    localparam int RATIO   = OUT_TDATA_WIDTH / IN_TDATA_WIDTH;
    localparam int IDX_W   = $clog2(RATIO);
    localparam int IKEEP_W = IN_TDATA_WIDTH / 8;
    localparam int OKEEP_W = OUT_TDATA_WIDTH / 8;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                beat_idx;
    logic                            pkt_open;
    logic [OUT_TDATA_WIDTH-1:0]      acc_data;
    logic [OKEEP_W-1:0]              acc_keep;
    logic [USERMETADATA_WIDTH-1:0]   acc_meta;
    SEGMENT_INFO_S                   acc_seg;
    logic                            acc_sop;

    logic                            accept;
    logic                            close;
    logic                            first_beat;
    logic [OUT_TDATA_WIDTH-1:0]      word_data;
    logic [OKEEP_W-1:0]              word_keep;
    logic [BYTESVLD_W-1:0]           word_cnt;
    logic [USERMETADATA_WIDTH-1:0]   word_meta;
    SEGMENT_INFO_S                   word_seg;

    // Ready never looks at in_tvalid; a held word frees its slot only on out_tready.
    assign in_tready  = !rst && (state_q == ACCUM || out_tready);
    assign accept     = in_tvalid && in_tready;
    assign first_beat = (beat_idx == '0);
    assign close      = accept &&
                        (beat_idx == IDX_W'(RATIO - 1) || in_tlast);
    assign out_tvalid = (state_q == HOLD);

    always_comb begin
        word_data = acc_data |
            ({{(OUT_TDATA_WIDTH-IN_TDATA_WIDTH){1'b0}}, in_tdata}
             << (int'(beat_idx) * IN_TDATA_WIDTH));
        word_keep = acc_keep |
            ({{(OKEEP_W-IKEEP_W){1'b0}}, in_tkeep}
             << (int'(beat_idx) * IKEEP_W));
    end

    ipbb_popcount #(
        .IN_W  (OKEEP_W),
        .CNT_W (BYTESVLD_W)
    ) u_popcount (
        .bits (word_keep),
        .cnt  (word_cnt)
    );

    always_comb begin
        word_meta         = first_beat ? in_tuser_usermetadata : acc_meta;
        word_seg          = first_beat ? in_tuser_segment_info : acc_seg;
        word_seg.sop      = first_beat ? !pkt_open : acc_sop;
        word_seg.eop      = in_tlast;
        word_seg.bytesvld = word_cnt;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM: if (close) state_d = HOLD;
            HOLD:  if (out_tready && !close) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= ACCUM;
            beat_idx               <= '0;
            pkt_open               <= 1'b0;
            acc_data               <= '0;
            acc_keep               <= '0;
            acc_meta               <= '0;
            acc_seg                <= '0;
            acc_sop                <= 1'b0;
            out_tdata              <= '0;
            out_tkeep              <= '0;
            out_tlast              <= 1'b0;
            out_tuser_usermetadata <= '0;
            out_tuser_segment_info <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pkt_open <= !in_tlast;
                if (close) begin
                    beat_idx               <= '0;
                    acc_data               <= '0;
                    acc_keep               <= '0;
                    out_tdata              <= word_data;
                    out_tkeep              <= word_keep;
                    out_tlast              <= in_tlast;
                    out_tuser_usermetadata <= word_meta;
                    out_tuser_segment_info <= word_seg;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                    acc_data <= word_data;
                    acc_keep <= word_keep;
                    if (first_beat) begin
                        acc_meta <= in_tuser_usermetadata;
                        acc_seg  <= in_tuser_segment_info;
                        acc_sop  <= !pkt_open;
                    end
                end
            end
        end
    end

`ifdef IGR_WADJ_SEG_MERGE_ERR_CHK_EN
    logic keep_contig;
    logic err_hit;
    logic err_q;

    // Contiguous-from-bit-0 means keep+1 shares no set bit with keep.
    assign keep_contig = ((in_tkeep & (in_tkeep + IKEEP_W'(1))) == '0);
    assign err_hit     = accept &&
                         ((in_tuser_segment_info.sop && pkt_open) ||
                          !keep_contig ||
                          (!in_tlast && !(&in_tkeep)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;
`else
    assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_igr_wadj_seg_merge.sv
// Bench for igr_wadj_seg_merge: vector table, corner sequences, random vs packet model.
module tb_igr_wadj_seg_merge;
    import ptp_bridge_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_tvalid = 1'b0;
    logic                 in_tready;
    logic [127:0]         in_tdata = '0;
    logic [15:0]          in_tkeep = '0;
    logic                 in_tlast = 1'b0;
    logic [0:0]           in_meta = '0;
    SEGMENT_INFO_S        in_seg = '0;
    logic                 out_tvalid;
    logic                 out_tready = 1'b1;
    logic [511:0]         out_tdata;
    logic [63:0]          out_tkeep;
    logic                 out_tlast;
    logic [0:0]           out_meta;
    SEGMENT_INFO_S        out_seg;
    logic                 err_sticky;

    igr_wadj_seg_merge dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_tvalid              (in_tvalid),
        .in_tready              (in_tready),
        .in_tdata               (in_tdata),
        .in_tkeep               (in_tkeep),
        .in_tlast               (in_tlast),
        .in_tuser_usermetadata  (in_meta),
        .in_tuser_segment_info  (in_seg),
        .out_tvalid             (out_tvalid),
        .out_tready             (out_tready),
        .out_tdata              (out_tdata),
        .out_tkeep              (out_tkeep),
        .out_tlast              (out_tlast),
        .out_tuser_usermetadata (out_meta),
        .out_tuser_segment_info (out_seg),
        .err_sticky             (err_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0]  data;
        logic [63:0]   keep;
        logic          last;
        logic          meta;
        SEGMENT_INFO_S seg;
    } word_t;

    typedef struct {
        int          nbeats;
        logic [15:0] last_keep;
        int          exp_words;
        logic        exp_first_eop;
        logic [63:0] exp_last_keep;
        int          exp_last_bv;
    } vec_t;

    word_t obs_q[$];
    int    obs_cyc[$];
    word_t exp_q[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    stall_acc = 0;
    bit    rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_tvalid && out_tready) begin
            obs_q.push_back({out_tdata, out_tkeep, out_tlast, out_meta[0], out_seg});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic SEGMENT_INFO_S mk_seg(input logic sop, input logic eop,
                                             input logic [15:0] k);
        SEGMENT_INFO_S s;
        s.sop      = sop;
        s.eop      = eop;
        s.bytesvld = 7'($countones(k));
        s.port_id  = 4'($urandom);
        s.pri      = 3'($urandom);
        return s;
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k,
                             input logic l, input logic m, input SEGMENT_INFO_S s,
                             output int stalls);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tkeep  = k;
        in_tlast  = l;
        in_meta   = m;
        in_seg    = s;
        stalls    = 0;
        forever begin
            @(negedge clk);
            if (in_tready) break;
            stalls++;
            if (stalls > 300) begin
                chk("beat_accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [15:0] lkeep, input bit model);
        logic [127:0]  d[16];
        logic [15:0]   k[16];
        logic          m[16];
        SEGMENT_INFO_S s[16];
        int            st;
        for (int i = 0; i < n; i++) begin
            d[i] = {$urandom, $urandom, $urandom, $urandom};
            k[i] = (i == n - 1) ? lkeep : 16'hFFFF;
            m[i] = 1'($urandom_range(0, 1));
            s[i] = mk_seg(i == 0, i == n - 1, k[i]);
        end
        if (model) begin
            for (int w = 0; w * 4 < n; w++) begin
                word_t e;
                int    bv;
                e  = '0;
                bv = 0;
                for (int b = 0; b < 4; b++) begin
                    int idx;
                    idx = w * 4 + b;
                    if (idx < n) begin
                        e.data[b*128 +: 128] = d[idx];
                        e.keep[b*16 +: 16]   = k[idx];
                        bv += $countones(k[idx]);
                    end
                end
                e.last         = (w * 4 + 4 >= n);
                e.meta         = m[w*4];
                e.seg          = s[w*4];
                e.seg.sop      = (w == 0);
                e.seg.eop      = e.last;
                e.seg.bytesvld = 7'(bv);
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            send_beat(d[i], k[i], i == n - 1, m[i], s[i], st);
            stall_acc += st;
        end
    endtask

    vec_t tbl[6];

    initial begin
        logic [127:0] da, db;
        bit           bad;
        int           st;
        int           wait_n;

        tbl[0] = '{4, 16'hFFFF, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        tbl[1] = '{6, 16'h00FF, 2, 1'b0, 64'h0000_0000_00FF_FFFF, 24};
        tbl[2] = '{1, 16'h0001, 1, 1'b1, 64'h0000_0000_0000_0001, 1};
        tbl[3] = '{5, 16'hFFFF, 2, 1'b0, 64'h0000_0000_0000_FFFF, 16};
        tbl[4] = '{8, 16'h7FFF, 2, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 63};
        tbl[5] = '{3, 16'h000F, 1, 1'b1, 64'h0000_000F_FFFF_FFFF, 36};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_tready", in_tready, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_out_tdata", out_tdata, 0);
        chk("rst_err", err_sticky, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(1);

        // vector table
        for (int t = 0; t < 6; t++) begin
            obs_q.delete();
            send_pkt(tbl[t].nbeats, tbl[t].last_keep, 1'b0);
            cycles(6);
            chk($sformatf("tbl%0d_words", t), obs_q.size(), tbl[t].exp_words);
            if (obs_q.size() > 0) begin
                chk($sformatf("tbl%0d_sop", t), obs_q[0].seg.sop, 1);
                chk($sformatf("tbl%0d_eop0", t), obs_q[0].seg.eop, tbl[t].exp_first_eop);
                chk($sformatf("tbl%0d_keep", t), obs_q[$].keep, tbl[t].exp_last_keep);
                chk($sformatf("tbl%0d_bv", t), obs_q[$].seg.bytesvld, tbl[t].exp_last_bv);
                chk($sformatf("tbl%0d_last", t), {obs_q[$].last, obs_q[$].seg.eop}, 2'b11);
            end
        end

        // back-to-back single-beat packets
        obs_q.delete();
        obs_cyc.delete();
        stall_acc = 0;
        for (int i = 0; i < 4; i++) send_pkt(1, 16'hFFFF, 1'b0);
        cycles(4);
        chk("b2b_stalls", stall_acc, 0);
        chk("b2b_words", obs_q.size(), 4);
        if (obs_cyc.size() == 4) chk("b2b_spacing", obs_cyc[3] - obs_cyc[0], 3);

        // egress stall with a second word waiting
        obs_q.delete();
        out_tready = 1'b0;
        da = {4{32'hA5A5_0001}};
        db = {4{32'h5A5A_0002}};
        send_beat(da, 16'hFFFF, 1'b1, 1'b0, mk_seg(1, 1, 16'hFFFF), st);
        in_tvalid = 1'b1;
        in_tdata  = db;
        in_tkeep  = 16'hFFFF;
        in_tlast  = 1'b1;
        in_seg    = mk_seg(1, 1, 16'hFFFF);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_tready !== 1'b0 || out_tvalid !== 1'b1 ||
                out_tdata !== {384'h0, da} || out_tkeep !== 64'hFFFF)
                bad = 1'b1;
        end
        chk("stall_stable", bad, 0);
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        @(negedge clk);
        chk("release_in_tready", in_tready, 1);
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("release_next_valid", out_tvalid, 1);
        chk("release_next_data", out_tdata, {384'h0, db});
        cycles(3);
        chk("release_words", obs_q.size(), 2);

        // reset mid-word
        obs_q.delete();
        send_beat({4{32'h1111_1111}}, 16'hFFFF, 1'b0, 1'b0, mk_seg(1, 0, 16'hFFFF), st);
        send_beat({4{32'h2222_2222}}, 16'hFFFF, 1'b0, 1'b0, mk_seg(0, 0, 16'hFFFF), st);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_tready", in_tready, 0);
        cycles(2);
        rst = 1'b0;
        cycles(4);
        chk("midrst_no_word", obs_q.size(), 0);
        send_beat({4{32'h3333_3333}}, 16'hFFFF, 1'b1, 1'b0, mk_seg(1, 1, 16'hFFFF), st);
        cycles(3);
        chk("postrst_words", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            chk("postrst_sop", obs_q[0].seg.sop, 1);
            chk("postrst_keep", obs_q[0].keep, 64'hFFFF);
            chk("postrst_data", obs_q[0].data, {384'h0, {4{32'h3333_3333}}});
        end

        // sop seen inside an open packet
        send_beat({4{32'h4444_4444}}, 16'hFFFF, 1'b0, 1'b0, mk_seg(1, 0, 16'hFFFF), st);
        send_beat({4{32'h5555_5555}}, 16'hFFFF, 1'b1, 1'b0, mk_seg(1, 1, 16'hFFFF), st);
        @(negedge clk);
`ifdef IGR_WADJ_SEG_MERGE_ERR_CHK_EN
        chk("err_set", err_sticky, 1);
        cycles(5);
        chk("err_held", err_sticky, 1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", err_sticky, 0);
        @(posedge clk);
        #1;
`else
        chk("err_tied0", err_sticky, 0);
        cycles(2);
`endif

        // random packets against the packet model
        cycles(3);
        obs_q.delete();
        exp_q.delete();
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 16);
            send_pkt($urandom_range(1, 9), 16'((17'd1 << len) - 17'd1), 1'b1);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        wait_n = 0;
        while (obs_q.size() < exp_q.size() && wait_n < 500) begin
            cycles(1);
            wait_n++;
        end
        cycles(3);
        chk("rand_word_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("rand%0d_data", i), obs_q[i].data, exp_q[i].data);
            chk($sformatf("rand%0d_keep", i), obs_q[i].keep, exp_q[i].keep);
            chk($sformatf("rand%0d_ctl", i),
                {obs_q[i].last, obs_q[i].meta, obs_q[i].seg},
                {exp_q[i].last, exp_q[i].meta, exp_q[i].seg});
        end
`ifndef IGR_WADJ_SEG_MERGE_ERR_CHK_EN
        chk("rand_err", err_sticky, 0);
`else
        chk("rand_err", err_sticky, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/igr_wadj_seg_merge.md
IGR_WADJ_SEG_MERGE -- requirements
Module: igr_wadj_seg_merge

Interface
REQ-001 SHALL have parameter IN_TDATA_WIDTH, default 128, narrow ingress data width.
REQ-002 SHALL have parameter IN_NUM_SEG, default 2, number of ingress segments per beat.
REQ-003 SHALL have parameter OUT_TDATA_WIDTH, default 512, wide egress data width; RATIO = OUT_TDATA_WIDTH/IN_TDATA_WIDTH, a power of two, at least 2.
REQ-004 SHALL have parameter USERMETADATA_WIDTH, default 1, user metadata width.
REQ-005 SHALL have ports, one per line as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_tvalid  in  1  ingress beat valid.
- in_tready  out  1  ingress ready.
- in_tdata  in  IN_NUM_SEG x IN_TDATA_WIDTH/IN_NUM_SEG  segmented data; segment 0 is the least significant.
- in_tkeep  in  IN_TDATA_WIDTH/8  byte enables.
- in_tlast  in  1  last beat of packet.
- in_tuser_usermetadata  in  USERMETADATA_WIDTH  metadata.
- in_tuser_segment_info  in  SEGMENT_INFO_S  segment info.
- out_tvalid  out  1  wide word valid.
- out_tready  in  1  egress ready.
- out_tdata  out  OUT_TDATA_WIDTH  merged data.
- out_tkeep  out  OUT_TDATA_WIDTH/8  merged byte enables.
- out_tlast  out  1  end of packet.
- out_tuser_usermetadata  out  USERMETADATA_WIDTH  metadata.
- out_tuser_segment_info  out  SEGMENT_INFO_S  rebuilt segment info.
- err_sticky  out  1  protocol error flag.

Function
REQ-006 SHALL pack consecutive ingress beats into one wide word; beat k of a word occupies bits [k*IN_TDATA_WIDTH +: IN_TDATA_WIDTH], with tkeep placed at the same offset.
REQ-007 SHALL keep a beat index, beat_idx, with width clog2(RATIO), reset 0; on an accepted beat it increments, and it returns to 0 after the word closes.
REQ-008 SHALL close a word on an accepted beat when beat_idx == RATIO-1 or when in_tlast = 1.
REQ-009 SHALL begin every packet at beat 0 of a new word (SOP-aligned); bytes of a word after tlast SHALL have tkeep = 0 and tdata = 0.
REQ-010 SHALL use a state machine with two states:
- ACCUM: collecting beats; this is the reset state.
- HOLD: a closed word sits in the output register with out_tvalid = 1.
REQ-011 Transitions: ACCUM->HOLD on close; HOLD->ACCUM on out_tready when no new word closes in the same cycle; HOLD->HOLD when out_tready and a close occur in the same cycle.
REQ-012 in_tready SHALL be 1 in ACCUM; in HOLD it SHALL be 1 only while out_tready = 1, with no combinational path from in_tvalid.
REQ-013 SHALL assert out_tvalid on the cycle after the closing beat is accepted (latency 1), and SHALL hold all out_* stable until out_tready.
REQ-014 SHALL build out_tuser_segment_info as follows:
- sop = 1 if the word holds the first beat of a packet.
- eop = out_tlast.
- bytesvld = popcount(out_tkeep), in the package field width.
- All other fields are copied from the word's beat 0.
REQ-015 out_tuser_usermetadata SHALL be taken from beat 0 of the word.
REQ-016 SHALL track packet start with a pkt_open flag: set on an accepted non-tlast beat, cleared on an accepted tlast beat, reset 0.

Reset
REQ-017 rst SHALL clear state to ACCUM, beat_idx to 0, pkt_open to 0, out_tvalid to 0, all out_* data/keep/tuser registers to 0, and err_sticky to 0.
REQ-018 rst asserted mid-word SHALL discard the partial word and emit nothing; in_tready SHALL be 0 during rst.

Configuration
REQ-019 With IGR_WADJ_SEG_MERGE_ERR_CHK_EN defined, err_sticky SHALL set, until reset, on any accepted beat where:
- segment_info.sop = 1 while pkt_open = 1; or
- tkeep is non-contiguous from bit 0; or
- tkeep is not all-ones on a non-tlast beat.
REQ-020 Without IGR_WADJ_SEG_MERGE_ERR_CHK_EN, err_sticky SHALL be tied to 0 and no check logic SHALL be built; data behaviour SHALL be identical in both builds.

Structure
REQ-021 SEGMENT_INFO_S and SEGMENT_INFO_WIDTH SHALL come from ptp_bridge_pkg; no new package types are needed.
REQ-022 SHALL instantiate one sub-module, ipbb_popcount, to compute bytesvld; there SHALL be no FIFO inside the block.

Verification
REQ-023 A 4-beat packet with all-ones tkeep and tlast on beat 3 -> one word, out_tkeep all ones, sop = 1, eop = 1, bytesvld = 64.
REQ-024 A 6-beat packet with beat 5 tkeep = 0x00FF -> word 1 with sop = 1, eop = 0; then word 2 with out_tkeep = 0x0000_0000_00FF_FFFF, eop = 1, bytesvld = 24.
REQ-025 Back-to-back 1-beat packets with out_tready = 1 -> one word per cycle, in_tready constant at 1, no bubble.
REQ-026 out_tready held 0 for 10 cycles while a word is HOLD -> in_tready = 0 and out_* stable; on release the next word follows on the next cycle.
REQ-027 rst asserted after beat 2 of a 4-beat packet -> no output word; the next packet starts at beat 0 with sop = 1.
REQ-028 With the macro defined, sop = 1 on beat 1 of an open packet -> err_sticky = 1 the next cycle and held until rst.
